// File: rtl/sm2_pkg.sv
// Shared SM2 constants, word geometry and the Montgomery reduction state encoding.
package sm2_pkg;

    localparam int WORD_W = 64;
    localparam int WORD_N = 4;

    localparam logic [255:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] SM2_N =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123;
    localparam logic [63:0] SM2_P_N0_INV = 64'd1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC_M = 3'd1,
        MAC    = 3'd2,
        PROP   = 3'd3,
        FSUB   = 3'd4
    } red_state_e;

endpackage

// File: rtl/mont_red_mac_64b.sv
// Combinational multiply-accumulate: {c_o,s_o} = a*b + x + c_in (never overflows 128b).
module mont_red_mac_64b
    import sm2_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic [WORD_W-1:0] x_i,
    input  logic [WORD_W-1:0] c_i,
    output logic [WORD_W-1:0] s_o,
    output logic [WORD_W-1:0] c_o
);

    logic [2*WORD_W-1:0] acc;

    assign acc = {{WORD_W{1'b0}}, a_i} * {{WORD_W{1'b0}}, b_i}
               + {{WORD_W{1'b0}}, x_i}
               + {{WORD_W{1'b0}}, c_i};

    assign s_o = acc[WORD_W-1:0];
    assign c_o = acc[2*WORD_W-1:WORD_W];

endmodule

// File: rtl/mont_red_sos_256b_64x1.sv
// Word-serial SOS Montgomery reduction U = T*2^-256 mod N using one 64x64 MAC.
// Define MONT_RED_FAST_M_EN to skip CALC_M (m = T[i], valid only when N0_INV == 1).
module mont_red_sos_256b_64x1
    import sm2_pkg::*;
#(
    parameter logic [255:0] MOD_N  = SM2_P,
    parameter logic [63:0]  N0_INV = SM2_P_N0_INV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         red_vld_i,
    input  logic [511:0] red_t_i,
    output logic         red_busy_o,
    output logic         red_fin_o,
    output logic [255:0] red_r_o
);

`ifdef MONT_RED_FAST_M_EN
    if (N0_INV != 64'd1) begin : g_n0_chk
        $error("MONT_RED_FAST_M_EN requires N0_INV == 1");
    end
`endif

    red_state_e state_q, state_d;

    logic [WORD_W-1:0] t_q [2*WORD_N];
    logic [WORD_W-1:0] t_d [2*WORD_N];
    logic [1:0]        i_q, i_d;
    logic [1:0]        j_q, j_d;
    logic [WORD_W-1:0] m_q, m_d;
    logic [WORD_W-1:0] c_q, c_d;
    logic              pend_q, pend_d;
    logic [255:0]      r_q, r_d;
    logic              fin_q, fin_d;

    logic [2:0]        idx_mac;
    logic [2:0]        idx_prop;
    logic [WORD_W-1:0] mac_a, mac_b, mac_x, mac_c;
    logic [WORD_W-1:0] mac_s, mac_co;
    logic [WORD_W:0]   prop_sum;
    logic [256:0]      v;
    logic [255:0]      v_sub;
    logic              v_ge;

    assign idx_mac  = {1'b0, i_q} + {1'b0, j_q};
    assign idx_prop = {1'b0, i_q} + 3'd4;

    assign prop_sum = {1'b0, t_q[idx_prop]} + {1'b0, c_q} + {{WORD_W{1'b0}}, pend_q};

    assign v     = {pend_q, t_q[7], t_q[6], t_q[5], t_q[4]};
    assign v_ge  = v >= {1'b0, MOD_N};
    // V < 2N, so the low 256 bits of V-N are exact whenever V >= N
    assign v_sub = v[255:0] - MOD_N;

    always_comb begin
        mac_a = m_q;
        mac_b = MOD_N[{j_q, 6'd0} +: WORD_W];
        mac_x = t_q[idx_mac];
        mac_c = c_q;
        if (state_q == CALC_M) begin
            mac_a = t_q[i_q];
            mac_b = N0_INV;
            mac_x = '0;
            mac_c = '0;
        end
    end

    mont_red_mac_64b u_mac (
        .a_i (mac_a),
        .b_i (mac_b),
        .x_i (mac_x),
        .c_i (mac_c),
        .s_o (mac_s),
        .c_o (mac_co)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        i_d     = i_q;
        j_d     = j_q;
        m_d     = m_q;
        c_d     = c_q;
        pend_d  = pend_q;
        r_d     = r_q;
        fin_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (red_vld_i) begin
                    for (int k = 0; k < 2*WORD_N; k++) begin
                        t_d[k] = red_t_i[k*WORD_W +: WORD_W];
                    end
                    i_d    = '0;
                    j_d    = '0;
                    c_d    = '0;
                    pend_d = 1'b0;
`ifdef MONT_RED_FAST_M_EN
                    m_d     = red_t_i[WORD_W-1:0];
                    state_d = MAC;
`else
                    state_d = CALC_M;
`endif
                end
            end
            CALC_M: begin
                m_d     = mac_s;
                j_d     = '0;
                c_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                t_d[idx_mac] = mac_s;
                c_d          = mac_co;
                j_d          = j_q + 2'd1;
                if (j_q == 2'd3) begin
                    state_d = PROP;
                end
            end
            PROP: begin
                // pend carries into the next PROP; MAC for i+1 never reaches T[i+5]
                t_d[idx_prop] = prop_sum[WORD_W-1:0];
                pend_d        = prop_sum[WORD_W];
                if (i_q == 2'd3) begin
                    state_d = FSUB;
                end else begin
                    i_d = i_q + 2'd1;
`ifdef MONT_RED_FAST_M_EN
                    m_d     = t_q[i_q + 2'd1];
                    j_d     = '0;
                    c_d     = '0;
                    state_d = MAC;
`else
                    state_d = CALC_M;
`endif
                end
            end
            FSUB: begin
                r_d     = v_ge ? v_sub : v[255:0];
                fin_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '{default: '0};
            i_q     <= '0;
            j_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            pend_q  <= 1'b0;
            r_q     <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            i_q     <= i_d;
            j_q     <= j_d;
            m_q     <= m_d;
            c_q     <= c_d;
            pend_q  <= pend_d;
            r_q     <= r_d;
            fin_q   <= fin_d;
        end
    end

    assign red_busy_o = (state_q != IDLE);
    assign red_fin_o  = fin_q;
    assign red_r_o    = r_q;

endmodule

// File: tb/tb_mont_red_sos_256b_64x1.sv
// Scoreboard bench for mont_red_sos_256b_64x1 (result, latency, busy window, aborts).
module tb_mont_red_sos_256b_64x1;

    localparam logic [255:0] P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
`ifdef MONT_RED_FAST_M_EN
    localparam int LAT = 21;
`else
    localparam int LAT = 25;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         vld;
    logic [511:0] t_in;
    logic         busy;
    logic         fin;
    logic [255:0] r;

    mont_red_sos_256b_64x1 dut (
        .clk        (clk),
        .rst        (rst),
        .red_vld_i  (vld),
        .red_t_i    (t_in),
        .red_busy_o (busy),
        .red_fin_o  (fin),
        .red_r_o    (r)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int fin_cnt  = 0;
    int busy_cnt = 0;
    logic [255:0] exp_q [$];
    longint       acc_q [$];

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Bit-serial Montgomery reference: halve 256 times, adding p when odd
    function automatic logic [255:0] mont_ref(input logic [511:0] tv);
        logic [512:0] x;
        x = {1'b0, tv};
        for (int k = 0; k < 256; k++) begin
            if (x[0]) x = x + {257'd0, P};
            x = x >> 1;
        end
        if (x >= {257'd0, P}) x = x - {257'd0, P};
        return x[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (fin) begin
                fin_cnt++;
                check("busy_fin_overlap", {255'd0, busy}, 256'd0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_fin: got fin with r=%h want no fin", r);
                end else begin
                    logic [255:0] e;
                    longint a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("result", r, e);
                    check("latency", 256'(cyc - a), 256'(LAT));
                    check("busy_len", 256'(busy_cnt), 256'(LAT));
                end
            end
            busy_cnt = busy ? busy_cnt + 1 : 0;
        end
    end

    task automatic run(input logic [511:0] tv, input logic [255:0] want,
                       input bit poke);
        int f0;
        bit done;
        f0 = fin_cnt;
        done = 1'b0;
        @(negedge clk);
        vld  = 1'b1;
        t_in = tv;
        @(posedge clk);
        #1;
        exp_q.push_back(want);
        acc_q.push_back(cyc);
        vld  = 1'b0;
        t_in = '0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            #1;
            vld = poke && k >= 5 && k < 8;
            if (vld) t_in = {rand256(), rand256()};
            if (fin_cnt > f0) done = 1'b1;
        end
        vld = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL fin_timeout: got no fin want fin within 60 cycles");
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end want end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] a;
        logic [255:0] b;
        logic [511:0] tv;
        rst  = 1'b1;
        vld  = 1'b0;
        t_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_fin", {255'd0, fin}, 256'd0);
        check("rst_r", r, 256'd0);
        @(negedge clk);
        rst = 1'b0;

        run(512'd0, 256'd0, 1'b0);
        run({256'd5, 256'd0}, 256'd5, 1'b0);
        run({P - 256'd1, 256'd0}, P - 256'd1, 1'b0);
        tv = {P - 256'd1, {256{1'b1}}};
        run(tv, mont_ref(tv), 1'b0);

        for (int n = 0; n < 1000; n++) begin
            a  = rand256() % P;
            b  = rand256() % P;
            tv = {256'd0, a} * {256'd0, b};
            run(tv, mont_ref(tv), (n % 50) == 0);
        end

        @(negedge clk);
        vld  = 1'b1;
        t_in = {256'd5, 256'd0};
        @(posedge clk);
        #1;
        vld = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {255'd0, busy}, 256'd0);
        check("abort_r", r, 256'd0);
        check("abort_fin", {255'd0, fin}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        run({255'd0, 1'b1, 256'd0}, 256'd1, 1'b0);

        repeat (5) @(negedge clk);
        check("queue_empty", 256'(exp_q.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
